// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer for the LC-3b pipeline.
// Runs the data-memory handshake for LDR/LDB/LDI/STR/STB/STI, including
// byte-lane steering and the pointer fetch for the indirect forms, and
// holds the pipeline stalled until the memory response arrives.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a valid memory op; captures it on acceptance
// S_IND_RD | LDI/STI pointer read in flight
// S_ACCESS | data read/write in flight
// S_DONE   | one-cycle completion pulse, pipeline released
module mem_access_unit #(
    parameter bit LDB_SEXT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [3:0]  opcode,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        stall,
    output logic [15:0] load_data,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IND_RD = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_STB) || (op == OP_LDR) ||
               (op == OP_STR) || (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_read_op(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_ind_op(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_byte_op(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] sdata_q, sdata_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] load_q, load_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [15:0] maddr_q, maddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        done_q, done_d;
    logic        stall_c;
    logic [15:0] eff_addr;
    logic [7:0]  rd_byte;

    // Next-state logic, operand capture and load-result formatting
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        ptr_d   = ptr_q;
        load_d  = load_q;
        stall_c = 1'b0;
        rd_byte = addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
        unique case (state_q)
            S_IDLE: begin
                if (valid_in && is_mem_op(opcode)) begin
                    op_d    = opcode;
                    addr_d  = addr;
                    sdata_d = store_data;
                    state_d = is_ind_op(opcode) ? S_IND_RD : S_ACCESS;
                    stall_c = 1'b1;
                end
            end
            S_IND_RD: begin
                stall_c = 1'b1;
                if (dmem_resp) begin
                    ptr_d   = {dmem_rdata[15:1], 1'b0};
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall_c = 1'b1;
                if (dmem_resp) begin
                    if (is_read_op(op_q)) begin
                        if (is_byte_op(op_q)) begin
                            load_d = LDB_SEXT ? {{8{rd_byte[7]}}, rd_byte}
                                              : {8'h00, rd_byte};
                        end else begin
                            load_d = dmem_rdata;
                        end
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request outputs for the state being entered, so they are valid in its first cycle
    always_comb begin
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        maddr_d  = 16'h0000;
        wdata_d  = 16'h0000;
        be_d     = 2'b00;
        eff_addr = is_ind_op(op_d) ? ptr_d : addr_d;
        done_d   = (state_d == S_DONE);
        if (state_d == S_IND_RD) begin
            rd_d    = 1'b1;
            maddr_d = {addr_d[15:1], 1'b0};
            be_d    = 2'b11;
        end else if (state_d == S_ACCESS) begin
            rd_d = is_read_op(op_d);
            wr_d = ~is_read_op(op_d);
            if (is_byte_op(op_d)) begin
                maddr_d = eff_addr;
                be_d    = eff_addr[0] ? 2'b10 : 2'b01;
                wdata_d = {sdata_d[7:0], sdata_d[7:0]};
            end else begin
                maddr_d = {eff_addr[15:1], 1'b0};
                be_d    = 2'b11;
                wdata_d = sdata_d;
            end
        end
    end

    // State, captured operands and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= 4'h0;
            addr_q  <= 16'h0000;
            sdata_q <= 16'h0000;
            ptr_q   <= 16'h0000;
            load_q  <= 16'h0000;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            maddr_q <= 16'h0000;
            wdata_q <= 16'h0000;
            be_q    <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ptr_q   <= ptr_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
        end
    end

    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_address     = maddr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_byte_enable = be_q;
    assign load_data        = load_q;
    assign done             = done_q;
    // Gated by reset so stall is low while reset is held, even with a memory op presented
    assign stall            = reset_n & stall_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: load/store word, byte, indirect and reset cases.
module tb_mem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic [3:0]  opcode;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;

    logic        dmem_read, dmem_write, stall, done;
    logic [15:0] dmem_address, dmem_wdata, load_data;
    logic [1:0]  dmem_byte_enable;

    logic        z_read, z_write, z_stall, z_done;
    logic [15:0] z_address, z_wdata, z_load;
    logic [1:0]  z_be;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int done_base;

    mem_access_unit #(.LDB_SEXT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .opcode(opcode),
        .addr(addr), .store_data(store_data), .dmem_resp(dmem_resp),
        .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .stall(stall),
        .load_data(load_data), .done(done)
    );

    mem_access_unit #(.LDB_SEXT(1'b0)) dut_z (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .opcode(opcode),
        .addr(addr), .store_data(store_data), .dmem_resp(dmem_resp),
        .dmem_rdata(dmem_rdata), .dmem_read(z_read), .dmem_write(z_write),
        .dmem_address(z_address), .dmem_wdata(z_wdata),
        .dmem_byte_enable(z_be), .stall(z_stall),
        .load_data(z_load), .done(z_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; valid_in = 1'b0; opcode = 4'h0; addr = 16'h0;
        store_data = 16'h0; dmem_resp = 1'b0; dmem_rdata = 16'h0;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_read", dmem_read, 0);
        chk("rst_write", dmem_write, 0);
        chk("rst_done", done, 0);
        chk("rst_load", load_data, 0);
        chk("rst_addr", dmem_address, 0);
        chk("rst_be", dmem_byte_enable, 0);
        #1 reset_n = 1'b1;

        // LDR 0x1235, response in the third ACCESS cycle
        tick();
        valid_in = 1'b1; opcode = 4'b0110; addr = 16'h1235;
        #1;
        chk("ldr_accept_stall", stall, 1);
        chk("ldr_accept_read", dmem_read, 0);
        tick();
        valid_in = 1'b0; opcode = 4'h0; addr = 16'h0;
        #1;
        chk("ldr_read", dmem_read, 1);
        chk("ldr_addr", dmem_address, 16'h1234);
        chk("ldr_be", dmem_byte_enable, 2'b11);
        chk("ldr_stall1", stall, 1);
        tick();
        #1;
        chk("ldr_read_hold", dmem_read, 1);
        chk("ldr_done_early", done, 0);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 16'hBEEF;
        #1;
        chk("ldr_stall3", stall, 1);
        tick();
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        #1;
        chk("ldr_done", done, 1);
        chk("ldr_load", load_data, 16'hBEEF);
        chk("ldr_stall_done", stall, 0);
        chk("ldr_read_off", dmem_read, 0);
        tick();
        #1;
        chk("ldr_done_pulse", done, 0);

        // LDB odd byte, both extension modes
        valid_in = 1'b1; opcode = 4'b0010; addr = 16'h2001;
        tick();
        valid_in = 1'b0; opcode = 4'h0;
        dmem_resp = 1'b1; dmem_rdata = 16'h80FF;
        #1;
        chk("ldb_read", dmem_read, 1);
        chk("ldb_addr", dmem_address, 16'h2001);
        chk("ldb_be", dmem_byte_enable, 2'b10);
        tick();
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        #1;
        chk("ldb_done", done, 1);
        chk("ldb_sext", load_data, 16'hFF80);
        chk("ldb_zext", z_load, 16'h0080);
        tick();

        // STB even byte
        valid_in = 1'b1; opcode = 4'b0011; addr = 16'h3000; store_data = 16'h12AB;
        tick();
        valid_in = 1'b0; opcode = 4'h0; store_data = 16'h0;
        #1;
        chk("stb_write", dmem_write, 1);
        chk("stb_read", dmem_read, 0);
        chk("stb_wdata", dmem_wdata, 16'hABAB);
        chk("stb_be", dmem_byte_enable, 2'b01);
        chk("stb_addr", dmem_address, 16'h3000);
        chk("stb_done_early", done, 0);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        #1;
        chk("stb_done", done, 1);
        chk("stb_write_off", dmem_write, 0);
        chk("stb_load_kept", load_data, 16'hFF80);
        tick();

        // STI through pointer 0x5001
        done_base = done_cnt;
        valid_in = 1'b1; opcode = 4'b1011; addr = 16'h4000; store_data = 16'h7777;
        tick();
        valid_in = 1'b0; opcode = 4'h0; addr = 16'h0; store_data = 16'h0;
        #1;
        chk("sti_ptr_read", dmem_read, 1);
        chk("sti_ptr_write", dmem_write, 0);
        chk("sti_ptr_addr", dmem_address, 16'h4000);
        chk("sti_ptr_be", dmem_byte_enable, 2'b11);
        dmem_resp = 1'b1; dmem_rdata = 16'h5001;
        tick();
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        #1;
        chk("sti_write", dmem_write, 1);
        chk("sti_read", dmem_read, 0);
        chk("sti_addr", dmem_address, 16'h5000);
        chk("sti_wdata", dmem_wdata, 16'h7777);
        chk("sti_be", dmem_byte_enable, 2'b11);
        chk("sti_stall", stall, 1);
        tick();
        dmem_resp = 1'b1;
        #1;
        chk("sti_write_hold", dmem_write, 1);
        tick();
        dmem_resp = 1'b0;
        #1;
        chk("sti_done", done, 1);
        tick();
        tick();
        chk("sti_one_done", done_cnt - done_base, 1);

        // ADD: not a memory op
        valid_in = 1'b1; opcode = 4'b0001; addr = 16'h1111;
        #1;
        chk("add_stall", stall, 0);
        tick();
        #1;
        chk("add_read", dmem_read, 0);
        chk("add_write", dmem_write, 0);
        chk("add_stall2", stall, 0);
        valid_in = 1'b0; opcode = 4'h0; addr = 16'h0;

        // LDI, immediate responses: three stall cycles
        tick();
        valid_in = 1'b1; opcode = 4'b1010; addr = 16'h7001;
        #1;
        chk("ldi_stall0", stall, 1);
        tick();
        valid_in = 1'b0; opcode = 4'h0; addr = 16'h0;
        dmem_resp = 1'b1; dmem_rdata = 16'h8003;
        #1;
        chk("ldi_ptr_addr", dmem_address, 16'h7000);
        chk("ldi_stall1", stall, 1);
        tick();
        dmem_rdata = 16'hA5A5;
        #1;
        chk("ldi_addr", dmem_address, 16'h8002);
        chk("ldi_read", dmem_read, 1);
        chk("ldi_stall2", stall, 1);
        tick();
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        #1;
        chk("ldi_done", done, 1);
        chk("ldi_load", load_data, 16'hA5A5);
        chk("ldi_stall3", stall, 0);
        tick();

        // Reset during LDI pointer wait
        valid_in = 1'b1; opcode = 4'b1010; addr = 16'h6000;
        tick();
        #1;
        chk("rmid_read_before", dmem_read, 1);
        #2;
        reset_n = 1'b0;
        dmem_resp = 1'b1; dmem_rdata = 16'h9999;
        #1;
        chk("rmid_read", dmem_read, 0);
        chk("rmid_stall", stall, 0);
        chk("rmid_addr", dmem_address, 0);
        valid_in = 1'b0; opcode = 4'h0; addr = 16'h0;
        #2 reset_n = 1'b1;
        tick();
        #1;
        chk("rmid_resp_ignored_done", done, 0);
        chk("rmid_resp_ignored_read", dmem_read, 0);
        dmem_resp = 1'b0; dmem_rdata = 16'h0;

        // LDR after reset recovery
        tick();
        valid_in = 1'b1; opcode = 4'b0110; addr = 16'h0102;
        tick();
        valid_in = 1'b0; opcode = 4'h0; addr = 16'h0;
        dmem_resp = 1'b1; dmem_rdata = 16'h1357;
        #1;
        chk("post_read", dmem_read, 1);
        chk("post_addr", dmem_address, 16'h0102);
        tick();
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        #1;
        chk("post_done", done, 1);
        chk("post_load", load_data, 16'h1357);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
